// File: rtl/store_pkg.sv
// Shared store-path definitions: funct3 codes, byte-mask constants and the FIFO entry layout.
package store_pkg;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    localparam logic [3:0] MASK_WORD    = 4'b1111;
    localparam logic [3:0] MASK_HALF_LO = 4'b0011;
    localparam logic [3:0] MASK_HALF_HI = 4'b1100;

    typedef struct packed {
        logic [29:0] waddr;
        logic [31:0] data;
        logic [3:0]  mask;
    } sb_entry_t;

endpackage

// File: rtl/store_align.sv
// Store width decode: byte-lane mask, lane-replicated write data and misaligned/illegal flag.
module store_align
    import store_pkg::*;
(
    input  logic [1:0]  addr,
    input  logic [31:0] data,
    input  logic [2:0]  funct3,
    output logic [3:0]  mask,
    output logic [31:0] wdata,
    output logic        err
);

    always_comb begin
        mask  = '0;
        wdata = data;
        err   = 1'b0;
        case (funct3)
            F3_SB: begin
                mask  = 4'b0001 << addr;
                wdata = {4{data[7:0]}};
            end
            F3_SH: begin
                mask  = addr[1] ? MASK_HALF_HI : MASK_HALF_LO;
                wdata = {2{data[15:0]}};
                err   = addr[0];
            end
            F3_SW: begin
                mask = MASK_WORD;
                err  = (addr != 2'b00);
            end
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/store_buffer.sv
// Store FIFO with memory drain and load/store address hazard detection.
// Define STORE_BUFFER_FWD_EN to forward full-word data from the youngest matching entry.
module store_buffer
    import store_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        st_valid,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic [2:0]  st_funct3,
    output logic        st_ready,
    output logic        store_err,
    input  logic        ld_check,
    input  logic [31:0] ld_addr,
    output logic        ld_hazard,
    output logic        fwd_valid,
    output logic [31:0] fwd_data,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_ready,
    output logic        empty
);

    localparam int PW = $clog2(DEPTH);

    sb_entry_t       entries [DEPTH];
    logic [PW:0]     head, tail, count;
    logic [3:0]      a_mask;
    logic [31:0]     a_data;
    logic            a_err;
    logic            full, accept, enq, deq;
    logic            hit, hit_word;
    logic [31:0]     hit_data;

    store_align u_align (
        .addr   (st_addr[1:0]),
        .data   (st_data),
        .funct3 (st_funct3),
        .mask   (a_mask),
        .wdata  (a_data),
        .err    (a_err)
    );

    assign count    = tail - head;
    assign empty    = (head == tail);
    assign full     = (head[PW] != tail[PW]) && (head[PW-1:0] == tail[PW-1:0]);
    assign st_ready = !full;
    assign accept   = st_valid && st_ready;
    assign enq      = accept && !a_err;
    assign mem_req  = !empty;
    assign deq      = mem_req && mem_ready;

    assign mem_addr  = {entries[head[PW-1:0]].waddr, 2'b00};
    assign mem_wdata = entries[head[PW-1:0]].data;
    assign mem_wmask = entries[head[PW-1:0]].mask;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head      <= '0;
            tail      <= '0;
            store_err <= 1'b0;
        end else begin
            store_err <= accept && a_err;
            if (enq) tail <= tail + 1'b1;
            if (deq) head <= head + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) entries[tail[PW-1:0]] <= '{waddr: st_addr[31:2], data: a_data, mask: a_mask};
    end

    // Walk oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        logic [PW:0] off;
        logic [PW-1:0] idx;
        hit      = 1'b0;
        hit_word = 1'b0;
        hit_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            off = (PW+1)'(k);
            idx = head[PW-1:0] + off[PW-1:0];
            if (ld_check && (off < count) && (entries[idx].waddr == ld_addr[31:2])) begin
                hit      = 1'b1;
                hit_word = (entries[idx].mask == MASK_WORD);
                hit_data = entries[idx].data;
            end
        end
    end

`ifdef STORE_BUFFER_FWD_EN
    assign ld_hazard = hit && !hit_word;
    assign fwd_valid = hit && hit_word;
    assign fwd_data  = (hit && hit_word) ? hit_data : 32'h0;
`else
    assign ld_hazard = hit;
    assign fwd_valid = 1'b0;
    assign fwd_data  = 32'h0;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: alignment table, drain scoreboard, hazard/forward/reset sequences.
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        st_valid;
    logic [31:0] st_addr, st_data;
    logic [2:0]  st_funct3;
    logic        st_ready, store_err;
    logic        ld_check;
    logic [31:0] ld_addr;
    logic        ld_hazard, fwd_valid;
    logic [31:0] fwd_data;
    logic        mem_req;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_ready;
    logic        empty;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  f3;
        logic        err;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_mask;
    } vec_t;

    store_buffer #(.DEPTH(2)) dut (
        .clk(clk), .reset(reset),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_funct3(st_funct3),
        .st_ready(st_ready), .store_err(store_err),
        .ld_check(ld_check), .ld_addr(ld_addr), .ld_hazard(ld_hazard),
        .fwd_valid(fwd_valid), .fwd_data(fwd_data),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_ready(mem_ready), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every handshake the DUT completes must match the oldest expectation.
    always @(negedge clk) begin
        if (reset && mem_req && mem_ready) begin
            if (sbq.size() == 0) begin
                chk("unexpected_pop", mem_addr, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("pop_addr", mem_addr, e.addr);
                chk("pop_wdata", mem_wdata, e.wdata);
                chk("pop_mask", {28'h0, mem_wmask}, {28'h0, e.mask});
            end
        end
    end

    // Called just after a posedge; returns just after the accepting posedge.
    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3,
                            input logic push, input logic [31:0] ea, input logic [31:0] ew,
                            input logic [3:0] em);
        st_valid = 1'b1; st_addr = a; st_data = d; st_funct3 = f3;
        if (push) sbq.push_back('{addr: ea, wdata: ew, mask: em});
        @(posedge clk); #1;
        st_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (!empty && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", {31'h0, empty}, 32'h1);
        @(posedge clk); #1;
    endtask

    vec_t vt[9];

    initial begin
        vt[0] = '{32'h0000_1003, 32'h0000_00AB, 3'b000, 1'b0, 32'h0000_1000, 32'hABAB_ABAB, 4'b1000};
        vt[1] = '{32'h0000_2000, 32'h1234_5678, 3'b000, 1'b0, 32'h0000_2000, 32'h7878_7878, 4'b0001};
        vt[2] = '{32'h0000_3002, 32'hCAFE_BEEF, 3'b001, 1'b0, 32'h0000_3000, 32'hBEEF_BEEF, 4'b1100};
        vt[3] = '{32'h0000_3000, 32'hCAFE_1234, 3'b001, 1'b0, 32'h0000_3000, 32'h1234_1234, 4'b0011};
        vt[4] = '{32'h0000_0040, 32'hDEAD_BEEF, 3'b010, 1'b0, 32'h0000_0040, 32'hDEAD_BEEF, 4'b1111};
        vt[5] = '{32'h0000_0101, 32'h0000_FFFF, 3'b001, 1'b1, 32'h0, 32'h0, 4'b0000};
        vt[6] = '{32'h0000_0102, 32'h1111_1111, 3'b010, 1'b1, 32'h0, 32'h0, 4'b0000};
        vt[7] = '{32'h0000_0100, 32'h2222_2222, 3'b011, 1'b1, 32'h0, 32'h0, 4'b0000};
        vt[8] = '{32'h0000_0000, 32'h3333_3333, 3'b100, 1'b1, 32'h0, 32'h0, 4'b0000};

        reset = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0; st_funct3 = '0;
        ld_check = 1'b0; ld_addr = '0; mem_ready = 1'b1;

        @(negedge clk);
        chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
        chk("rst_empty", {31'h0, empty}, 32'h1);
        chk("rst_st_ready", {31'h0, st_ready}, 32'h1);
        chk("rst_store_err", {31'h0, store_err}, 32'h0);
        chk("rst_ld_hazard", {31'h0, ld_hazard}, 32'h0);
        chk("rst_fwd_valid", {31'h0, fwd_valid}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // Alignment table with mem_ready high: good stores drain, bad ones pulse store_err.
        for (int i = 0; i < 9; i++) begin
            do_store(vt[i].addr, vt[i].data, vt[i].f3, !vt[i].err,
                     vt[i].e_addr, vt[i].e_wdata, vt[i].e_mask);
            @(negedge clk);
            chk($sformatf("v%0d_store_err", i), {31'h0, store_err}, {31'h0, vt[i].err});
            chk($sformatf("v%0d_mem_req", i), {31'h0, mem_req}, {31'h0, !vt[i].err});
            @(posedge clk); #1;
            @(negedge clk);
            chk($sformatf("v%0d_err_clear", i), {31'h0, store_err}, 32'h0);
            chk($sformatf("v%0d_empty", i), {31'h0, empty}, 32'h1);
            @(posedge clk); #1;
        end

        // Hazard: SB pending at 0x1000.
        mem_ready = 1'b0;
        do_store(32'h1000, 32'h55, 3'b000, 1'b1, 32'h1000, 32'h5555_5555, 4'b0001);
        ld_check = 1'b1; ld_addr = 32'h1002;
        @(negedge clk);
        chk("haz_same_word", {31'h0, ld_hazard}, 32'h1);
        chk("haz_sb_no_fwd", {31'h0, fwd_valid}, 32'h0);
        ld_addr = 32'h1004;
        @(negedge clk);
        chk("haz_other_word", {31'h0, ld_hazard}, 32'h0);
        @(posedge clk); #1;
        // A store enqueuing alongside the load is younger and is not compared.
        st_valid = 1'b1; st_addr = 32'h1004; st_data = 32'h7777_7777; st_funct3 = 3'b010;
        sbq.push_back('{addr: 32'h1004, wdata: 32'h7777_7777, mask: 4'b1111});
        @(negedge clk);
        chk("haz_same_cycle_enq", {31'h0, ld_hazard}, 32'h0);
        @(posedge clk); #1;
        st_valid = 1'b0;
        @(negedge clk);
        chk("full_st_ready", {31'h0, st_ready}, 32'h0);
`ifdef STORE_BUFFER_FWD_EN
        chk("fwd_sw_hazard", {31'h0, ld_hazard}, 32'h0);
        chk("fwd_sw_valid", {31'h0, fwd_valid}, 32'h1);
        chk("fwd_sw_data", fwd_data, 32'h7777_7777);
`else
        chk("nofwd_sw_hazard", {31'h0, ld_hazard}, 32'h1);
        chk("nofwd_fwd_valid", {31'h0, fwd_valid}, 32'h0);
`endif
        @(posedge clk); #1;
        mem_ready = 1'b1; ld_addr = 32'h1000;
        @(negedge clk);
        chk("haz_popping_entry", {31'h0, ld_hazard}, 32'h1);
        chk("full_deq_no_bypass", {31'h0, st_ready}, 32'h0);
        @(posedge clk); #1;
        ld_check = 1'b0;
        wait_drain();

        // Backpressure: two SWs fill the buffer, head held stable.
        mem_ready = 1'b0;
        do_store(32'h20, 32'h1111_1111, 3'b010, 1'b1, 32'h20, 32'h1111_1111, 4'b1111);
        do_store(32'h24, 32'h2222_2222, 3'b010, 1'b1, 32'h24, 32'h2222_2222, 4'b1111);
        st_valid = 1'b1; st_addr = 32'h28; st_data = 32'h3333_3333; st_funct3 = 3'b010;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("bp_st_ready", {31'h0, st_ready}, 32'h0);
            chk("bp_mem_req", {31'h0, mem_req}, 32'h1);
            chk("bp_mem_addr", mem_addr, 32'h20);
            chk("bp_mem_wmask", {28'h0, mem_wmask}, 32'hF);
            @(posedge clk); #1;
        end
        st_valid = 1'b0;
        mem_ready = 1'b1;
        wait_drain();

        // Forwarding / youngest-entry selection at 0x40.
        mem_ready = 1'b0;
        do_store(32'h40, 32'hDEAD_BEEF, 3'b010, 1'b1, 32'h40, 32'hDEAD_BEEF, 4'b1111);
        ld_check = 1'b1; ld_addr = 32'h40;
        @(negedge clk);
`ifdef STORE_BUFFER_FWD_EN
        chk("fwd40_valid", {31'h0, fwd_valid}, 32'h1);
        chk("fwd40_data", fwd_data, 32'hDEAD_BEEF);
        chk("fwd40_hazard", {31'h0, ld_hazard}, 32'h0);
`else
        chk("fwd40_valid", {31'h0, fwd_valid}, 32'h0);
        chk("fwd40_data", fwd_data, 32'h0);
        chk("fwd40_hazard", {31'h0, ld_hazard}, 32'h1);
`endif
        @(posedge clk); #1;
        do_store(32'h40, 32'h11, 3'b000, 1'b1, 32'h40, 32'h1111_1111, 4'b0001);
        @(negedge clk);
        chk("young_sb_hazard", {31'h0, ld_hazard}, 32'h1);
        chk("young_sb_fwd", {31'h0, fwd_valid}, 32'h0);
        @(posedge clk); #1;
        ld_check = 1'b0; mem_ready = 1'b1;
        wait_drain();

        // Reset with two entries pending discards them at once.
        mem_ready = 1'b0;
        do_store(32'h80, 32'hAAAA_AAAA, 3'b010, 1'b0, 32'h0, 32'h0, 4'h0);
        do_store(32'h84, 32'hBBBB_BBBB, 3'b010, 1'b0, 32'h0, 32'h0, 4'h0);
        chk("pre_rst_mem_req", {31'h0, mem_req}, 32'h1);
        #1 reset = 1'b0;
        #1;
        chk("rst_async_mem_req", {31'h0, mem_req}, 32'h0);
        chk("rst_async_empty", {31'h0, empty}, 32'h1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_empty", {31'h0, empty}, 32'h1);
        chk("post_rst_st_ready", {31'h0, st_ready}, 32'h1);
        chk("post_rst_mem_req", {31'h0, mem_req}, 32'h0);

        chk("scoreboard_left", sbq.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
